// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: controller-side handshake and HI/LO bus of the multiply/divide unit
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, wr_hi, wr_lo, wdata, input busy, done, hi, lo);
  modport slave (input start, op, a, b, wr_hi, wr_lo, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 shift-add multiply / restoring divide owning HI/LO
// Define MULDIV_DIV_EN to include the divide datapath (DIVU/DIV); otherwise divide starts are ignored.
module mul_div_unit #(parameter int WIDTH = 32) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic neg_q, neg_d, busy_q, busy_d, done_q, done_d;
  logic accept, sa, sb;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_DIV_EN
  logic div_q, div_d, neg_r_q, neg_r_d, dz_q, dz_d, ge;
  logic [WIDTH:0] sh;
  logic [WIDTH-1:0] diff;
`endif
  always_comb begin
`ifdef MULDIV_DIV_EN
    accept = bus.start && !busy_q;
`else
    accept = bus.start && !busy_q && !bus.op[1];
`endif
    sa = bus.op[0] && bus.a[WIDTH-1];
    sb = bus.op[0] && bus.b[WIDTH-1];
    ma = sa ? -bus.a : bus.a;
    mb = sb ? -bus.b : bus.b;
    // p_hi accumulates the partial product (or remainder); p_lo shifts out multiplier bits (or in quotient bits)
    sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, m_q} : '0);
    prod = neg_q ? -{p_hi_q, p_lo_q} : {p_hi_q, p_lo_q};
    state_d = state_q;
    cnt_d = cnt_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    m_d = m_q;
    hi_d = hi_q;
    lo_d = lo_q;
    neg_d = neg_q;
    busy_d = busy_q;
    done_d = 1'b0;
`ifdef MULDIV_DIV_EN
    sh = {p_hi_q, p_lo_q[WIDTH-1]};
    ge = sh >= {1'b0, m_q};
    diff = sh[WIDTH-1:0] - m_q;
    div_d = div_q;
    neg_r_d = neg_r_q;
    dz_d = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          p_hi_d = '0;
          p_lo_d = bus.op[1] ? ma : mb;
          m_d = bus.op[1] ? mb : ma;
          neg_d = sa ^ sb;
          cnt_d = CW'(WIDTH);
          state_d = CALC;
          busy_d = 1'b1;
`ifdef MULDIV_DIV_EN
          div_d = bus.op[1];
          neg_r_d = sa;
          dz_d = bus.op[1] && bus.b == '0;
`endif
        end else begin
          hi_d = bus.wr_hi ? bus.wdata : hi_q;
          lo_d = bus.wr_lo ? bus.wdata : lo_q;
        end
      end
      CALC: begin
        p_hi_d = sum[WIDTH:1];
        p_lo_d = {sum[0], p_lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          p_hi_d = ge ? diff : sh[WIDTH-1:0];
          p_lo_d = {p_lo_q[WIDTH-2:0], ge};
        end
`endif
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? FIX : CALC;
      end
      FIX: begin
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        // divide by zero leaves rem=|a| with quotient all ones; re-signing rem restores a
        if (div_q) begin
          lo_d = dz_q ? '1 : (neg_q ? -p_lo_q : p_lo_q);
          hi_d = neg_r_q ? -p_hi_q : p_hi_q;
        end
`endif
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      p_hi_q <= '0;
      p_lo_q <= '0;
      m_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      neg_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
      m_q <= m_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      neg_q <= neg_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef MULDIV_DIV_EN
      div_q <= div_d;
      neg_r_q <= neg_r_d;
      dz_q <= dz_d;
`endif
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit (divide tests under MULDIV_DIV_EN)
module tb_mul_div_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mul_div_unit_if #(.WIDTH(W)) bus();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    step();
    bus.start = 1'b0;
    lat = 0; bcnt = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.wr_hi = 0; bus.wr_lo = 0; bus.wdata = 0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_multu();
    int lat, bc;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", bus.done); end
  endtask

  task automatic test_mult();
    int lat, bc;
    run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, lat, bc);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_neg3x7 got %h_%h want ffffffff_ffffffeb", bus.hi, bus.lo); end
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    checks++; if ({bus.hi, bus.lo} !== 64'h00000000_00000001) begin errors++; $display("FAIL mult_neg1xneg1 got %h_%h want 00000000_00000001", bus.hi, bus.lo); end
    run_op(2'b01, 32'h80000000, 32'h80000000, lat, bc);
    checks++; if ({bus.hi, bus.lo} !== 64'h40000000_00000000) begin errors++; $display("FAIL mult_minsq got %h_%h want 40000000_00000000", bus.hi, bus.lo); end
    run_op(2'b01, 32'h00001234, 32'hFFFFFFFE, lat, bc);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFDB98) begin errors++; $display("FAIL mult_pos_x_neg2 got %h_%h want ffffffff_ffffdb98", bus.hi, bus.lo); end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int lat, bc;
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, lat, bc);
    checks++; if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg7_2 got hi=%h lo=%h want ffffffff fffffffd", bus.hi, bus.lo); end
    run_op(2'b11, 32'h00000007, 32'hFFFFFFFE, lat, bc);
    checks++; if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'h00000001) begin errors++; $display("FAIL div_7_neg2 got hi=%h lo=%h want 00000001 fffffffd", bus.hi, bus.lo); end
    run_op(2'b10, 32'd100, 32'd0, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_zero_latency got %0d want 33", lat); end
    checks++; if (bus.lo !== 32'hFFFFFFFF || bus.hi !== 32'd100) begin errors++; $display("FAIL divu_by_zero got hi=%h lo=%h want 00000064 ffffffff", bus.hi, bus.lo); end
    run_op(2'b11, 32'hFFFFFFFB, 32'd0, lat, bc);
    checks++; if (bus.lo !== 32'hFFFFFFFF || bus.hi !== 32'hFFFFFFFB) begin errors++; $display("FAIL div_neg_by_zero got hi=%h lo=%h want fffffffb ffffffff", bus.hi, bus.lo); end
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++; if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0) begin errors++; $display("FAIL div_overflow got hi=%h lo=%h want 00000000 80000000", bus.hi, bus.lo); end
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, lat, bc);
    checks++; if (bus.lo !== 32'h7FFFFFFC || bus.hi !== 32'h00000001) begin errors++; $display("FAIL divu_large got hi=%h lo=%h want 00000001 7ffffffc", bus.hi, bus.lo); end
  endtask
`else
  task automatic test_div_disabled();
    int lat, bc, seen;
    bus.wr_hi = 1'b1; bus.wdata = 32'hAAAA0001; step();
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wdata = 32'hBBBB0002; step();
    bus.wr_lo = 1'b0;
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd9; bus.b = 32'd3;
    step();
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy || bus.done) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL nodiv_busy_done got %0d active cycles want 0", seen); end
    checks++; if (bus.hi !== 32'hAAAA0001 || bus.lo !== 32'hBBBB0002) begin errors++; $display("FAIL nodiv_hilo got hi=%h lo=%h want aaaa0001 bbbb0002", bus.hi, bus.lo); end
    run_op(2'b00, 32'd2, 32'd3, lat, bc);
    checks++; if (lat !== 33 || bus.lo !== 32'd6 || bus.hi !== 32'd0) begin errors++; $display("FAIL nodiv_multu got lat=%0d hi=%h lo=%h want 33 0 6", lat, bus.hi, bus.lo); end
  endtask
`endif

  task automatic test_mthi_mtlo();
    bus.wr_hi = 1'b1; bus.wdata = 32'h00001234;
    step();
    bus.wr_hi = 1'b0;
    checks++; if (bus.hi !== 32'h00001234 || bus.done !== 1'b0) begin errors++; $display("FAIL mthi got hi=%h done=%b want 00001234 0", bus.hi, bus.done); end
    bus.wr_lo = 1'b1; bus.wdata = 32'h00005678;
    step();
    bus.wr_lo = 1'b0;
    checks++; if (bus.lo !== 32'h00005678 || bus.hi !== 32'h00001234) begin errors++; $display("FAIL mtlo got hi=%h lo=%h want 00001234 00005678", bus.hi, bus.lo); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd6; bus.b = 32'd7;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9; bus.wr_hi = 1'b1; bus.wdata = 32'h55;
    step();
    bus.start = 1'b0; bus.wr_hi = 1'b0;
    lat = 5;
    while (!bus.done && lat < 100) begin step(); lat++; end
    checks++; if (lat !== 33) begin errors++; $display("FAIL busy_ignore_latency got %0d want 33", lat); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd42) begin errors++; $display("FAIL busy_ignore_result got hi=%h lo=%h want 0 2a", bus.hi, bus.lo); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [W-1:0] eh, el;
`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'd10, 32'd3, lat, bc);
    eh = 32'd1; el = 32'd3;
`else
    run_op(2'b00, 32'd6, 32'd7, lat, bc);
    eh = 32'd0; el = 32'd42;
`endif
    checks++; if (bus.done !== 1'b1 || bus.hi !== eh || bus.lo !== el) begin errors++; $display("FAIL b2b_first got done=%b hi=%h lo=%h want 1 %h %h", bus.done, bus.hi, bus.lo, eh, el); end
    run_op(2'b00, 32'd5, 32'd5, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd25) begin errors++; $display("FAIL b2b_second got hi=%h lo=%h want 0 19", bus.hi, bus.lo); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd6; bus.b = 32'd7;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b want 0 0 0", bus.hi, bus.lo, bus.busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Sits beside the ALU in the execute stage. It is started by MULT/MULTU/DIV/DIVU from the controller and supplies HI/LO to the register file for MFHI/MFLO.
- Exposes a busy/done handshake so the controller can stall the PC while an operation is in flight.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- WIDTH, 32, operand width and HI/LO width; must be >= 2. The iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin operation; sampled only when busy=0
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight; controller stalls on it
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- hi  out  WIDTH  HI register (MULT upper product / DIV remainder)
- lo  out  WIDTH  LO register (MULT lower product / DIV quotient)

Behaviour:
- Reset is synchronous, active-high, clock clk. On reset: hi=0, lo=0, busy=0, done=0, FSM=IDLE.
- Reset mid-operation aborts the operation; no done pulse is produced.
- FSM has three states: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0 captures a, b and op. For signed ops the operands are converted to magnitudes and the result sign is recorded.
  - Counter loads WIDTH; FSM goes to CALC; busy=1 after E0.
- CALC:
  - One multiply/divide iteration per cycle; counter decrements.
  - After WIDTH cycles, go to FIX.
- FIX:
  - Apply sign correction and special cases.
  - Write hi/lo at edge E0+WIDTH+1; go to IDLE.
  - In the cycle after that edge: done=1 and busy=0, with hi/lo already valid.
- Latency: start-sample edge to result edge = WIDTH+1 cycles (33 for WIDTH=32). busy is high for exactly WIDTH+1 cycles.
- start while busy=1: ignored.
- start in the same cycle that done=1: accepted, so back-to-back operations have no bubble.
- Multiply results:
  - MULTU: {hi,lo} = a*b, unsigned, 2*WIDTH bits.
  - MULT: two's-complement product, 2*WIDTH bits.
- Divide results:
  - DIVU: lo = a/b, hi = a%b.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (both DIVU and DIV): lo = all ones, hi = a. Full latency is still taken.
- DIV overflow, a = most-negative and b = -1: lo = a, hi = 0.
- wr_hi/wr_lo with busy=0 and start=0: write wdata to hi/lo at the next edge. No done pulse.
- wr_hi/wr_lo with busy=1, or in the same cycle as an accepted start: ignored.
- hi/lo hold their values at all other times. Outputs come directly from registers; there is no combinational path from inputs to outputs.

Optional Feature:
- MULDIV_DIV_EN
- Defined: divide datapath is present; DIVU/DIV behave as above.
- Undefined: no divider logic. start with op[1]=1 is ignored: busy stays 0, no done pulse, hi/lo unchanged. Multiply behaviour is identical in both builds.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU 6*7; pulse start with other operands and assert wr_hi (wdata=0x55) during busy -> both ignored; result hi=0, lo=42.
- Start DIVU 10/3; assert start with MULTU 5*5 in the done cycle of the DIVU -> first result hi=1, lo=3; second done 33 cycles later with hi=0, lo=25. Reset asserted at cycle 10 of a further op -> hi=lo=0, busy=0, no done.
- Build without MULDIV_DIV_EN: start DIVU 9/3 -> busy stays 0, no done, hi/lo unchanged. MULTU 2*3 -> lo=6.
